// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl
// Description : Program-counter and instruction-fetch controller for the IF
//               stage. Holds the fetch PC, issues word requests to the
//               instruction memory over a request/grant handshake, and
//               handles stalls, branch/jump redirects, a halt address,
//               misaligned-target trapping and a saturating fetch counter.
//
// Ports:
//   clk          in   clock, rising-edge
//   rst_n        in   asynchronous active-low reset
//   stall        in   hazard stall: no fetch, PC held
//   redir_valid  in   redirect strobe from EX
//   redir_target in   redirect target address
//   im_req       out  fetch request to instruction memory
//   im_addr      out  word address of the request (pc[IM_AW+1:2])
//   im_gnt       in   memory accepts the request this cycle
//   pc           out  current fetch PC
//   if_valid     out  fetched instruction valid for decode
//   if_pc        out  PC of the instruction qualified by if_valid
//   halted       out  controller is in HALT
//   misalign     out  sticky misaligned-redirect flag
//   fetch_cnt    out  saturating count of delivered fetches
//
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl #(
    parameter int              XLEN      = 32,
    parameter int              IM_AW     = 14,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter bit              HALT_EN   = 1'b1,
    parameter logic [XLEN-1:0] HALT_ADDR = 2048,
    parameter int              CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redir_valid,
    input  logic [XLEN-1:0]  redir_target,
    output logic             im_req,
    output logic [IM_AW-1:0] im_addr,
    input  logic             im_gnt,
    output logic [XLEN-1:0]  pc,
    output logic             if_valid,
    output logic [XLEN-1:0]  if_pc,
    output logic             halted,
    output logic             misalign,
    output logic [CNT_W-1:0] fetch_cnt
);

    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t           r_state;
    logic [XLEN-1:0]  r_pc;
    logic             r_if_valid;
    logic [XLEN-1:0]  r_if_pc;
    logic             r_misalign;
    logic [CNT_W-1:0] r_fetch_cnt;

    logic w_at_halt;
    logic w_redir_ok;
    logic w_redir_bad;
    logic w_req;
    logic w_acc;
    logic w_deliver;

    // The halt address is compared against the current PC; when it matches
    // the request is withheld, so that address is never fetched.
    assign w_at_halt   = HALT_EN && (r_pc == HALT_ADDR);
    assign w_redir_bad = redir_valid && (redir_target[1:0] != 2'b00);
    assign w_redir_ok  = redir_valid && (redir_target[1:0] == 2'b00);

    assign w_req     = (r_state == ST_RUN) && !stall && !w_at_halt;
    assign w_acc     = w_req && im_gnt;
    // Any redirect in the accept cycle (aligned or not) kills that fetch.
    assign w_deliver = w_acc && !redir_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_BOOT;
            r_pc        <= RESET_VEC;
            r_if_valid  <= 1'b0;
            r_if_pc     <= '0;
            r_misalign  <= 1'b0;
            r_fetch_cnt <= '0;
        end else begin
            r_if_valid <= w_deliver;
            if (w_acc) begin
                r_if_pc <= r_pc;
            end
            if (w_deliver && !(&r_fetch_cnt)) begin
                r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
            end

            case (r_state)
                ST_BOOT: begin
                    if (w_redir_bad) begin
                        r_state    <= ST_ERR;
                        r_misalign <= 1'b1;
                    end else begin
                        if (w_redir_ok) begin
                            r_pc <= redir_target;
                        end
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (w_redir_bad) begin
                        r_state    <= ST_ERR;
                        r_misalign <= 1'b1;
                    end else if (w_redir_ok) begin
                        r_pc <= redir_target;
                    end else begin
                        if (w_acc) begin
                            r_pc <= r_pc + c_PC_STEP;
                        end
                        if (w_at_halt) begin
                            r_state <= ST_HALT;
                        end
                    end
                end

                ST_HALT: begin
                    if (w_redir_bad) begin
                        r_state    <= ST_ERR;
                        r_misalign <= 1'b1;
                    end else if (w_redir_ok) begin
                        r_pc    <= redir_target;
                        r_state <= ST_RUN;
                    end
                end

                ST_ERR: begin
                    // Terminal until reset; redirects are ignored.
                    r_state <= ST_ERR;
                end

                default: begin
                    r_state <= ST_ERR;
                end
            endcase
        end
    end

    assign im_req    = w_req;
    assign im_addr   = r_pc[IM_AW+1:2];
    assign pc        = r_pc;
    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign halted    = (r_state == ST_HALT);
    assign misalign  = r_misalign;
    assign fetch_cnt = r_fetch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_ctrl
// Description : Self-checking bench for pc_fetch_ctrl. Expected if_pc values
//               are queued as fetches are driven and compared when if_valid
//               is observed; other outputs are compared against constants.
//               A second instance covers PC wrap and counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        im_gnt;
    logic        im_req;
    logic [13:0] im_addr;
    logic [31:0] pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        halted;
    logic        misalign;
    logic [31:0] fetch_cnt;

    logic        rst2_n;
    logic        gnt2;
    logic        im_req2;
    logic [13:0] im_addr2;
    logic [31:0] pc2;
    logic        if_valid2;
    logic [31:0] if_pc2;
    logic        halted2;
    logic        misalign2;
    logic [1:0]  fetch_cnt2;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    pc_fetch_ctrl u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .im_req       (im_req),
        .im_addr      (im_addr),
        .im_gnt       (im_gnt),
        .pc           (pc),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .halted       (halted),
        .misalign     (misalign),
        .fetch_cnt    (fetch_cnt)
    );

    pc_fetch_ctrl #(
        .RESET_VEC (32'hFFFF_FFF0),
        .HALT_EN   (1'b0),
        .CNT_W     (2)
    ) u_dut_wrap (
        .clk          (clk),
        .rst_n        (rst2_n),
        .stall        (1'b0),
        .redir_valid  (1'b0),
        .redir_target (32'h0),
        .im_req       (im_req2),
        .im_addr      (im_addr2),
        .im_gnt       (gnt2),
        .pc           (pc2),
        .if_valid     (if_valid2),
        .if_pc        (if_pc2),
        .halted       (halted2),
        .misalign     (misalign2),
        .fetch_cnt    (fetch_cnt2)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Drive one cycle from just after a rising edge: check the request-side
    // outputs, queue the expected delivered PC, then advance past the edge.
    task automatic drive_cycle(input logic s, input logic rv, input logic [31:0] rt,
                               input logic g, input logic exp_req, input logic [31:0] exp_pc);
        stall        = s;
        redir_valid  = rv;
        redir_target = rt;
        im_gnt       = g;
        #1;
        check("im_req", im_req, exp_req);
        check("pc", pc, exp_pc);
        check("im_addr", im_addr, exp_pc[15:2]);
        if (exp_req && g && !rv) sb_q.push_back(exp_pc);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every delivered instruction must match the oldest queued PC.
    always @(negedge clk) begin
        if (rst_n && if_valid) begin
            if (sb_q.size() == 0) check("if_valid_unexpected", 1, 0);
            else check("if_pc", if_pc, sb_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0; gnt2 = 1'b0;
        stall = 1'b0; redir_valid = 1'b0; redir_target = '0; im_gnt = 1'b0;
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_im_req", im_req, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_halted", halted, 0);
        check("rst_misalign", misalign, 0);
        check("rst_fetch_cnt", fetch_cnt, 0);

        // Sequential fetch after one BOOT cycle
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_cycle(0, 0, 0, 1, 0, 32'h0);
        drive_cycle(0, 0, 0, 1, 1, 32'h0);
        drive_cycle(0, 0, 0, 1, 1, 32'h4);
        drive_cycle(0, 0, 0, 1, 1, 32'h8);
        check("fetch_cnt_3", fetch_cnt, 3);

        // Redirect kills the fetch accepted in the same cycle
        drive_cycle(0, 1, 32'h20, 0, 1, 32'hC);
        drive_cycle(0, 1, 32'h100, 1, 1, 32'h20);
        check("kill_if_valid", if_valid, 0);
        drive_cycle(0, 0, 0, 1, 1, 32'h100);
        drive_cycle(0, 1, 32'h40, 0, 1, 32'h104);

        // Stall with a redirect on the second stalled cycle
        drive_cycle(1, 0, 0, 1, 0, 32'h40);
        drive_cycle(1, 1, 32'h80, 1, 0, 32'h40);
        drive_cycle(1, 0, 0, 1, 0, 32'h80);
        drive_cycle(0, 0, 0, 1, 1, 32'h80);

        // Halt address 0x800 reached from 0x7F8
        drive_cycle(0, 1, 32'h7F8, 0, 1, 32'h84);
        drive_cycle(0, 0, 0, 1, 1, 32'h7F8);
        drive_cycle(0, 0, 0, 1, 1, 32'h7FC);
        drive_cycle(0, 0, 0, 1, 0, 32'h800);
        check("halted", halted, 1);
        drive_cycle(1, 0, 0, 1, 0, 32'h800);
        check("halted_hold", halted, 1);
        drive_cycle(0, 1, 32'h10, 1, 0, 32'h800);
        check("halted_exit", halted, 0);
        drive_cycle(0, 0, 0, 1, 1, 32'h10);

        // Misaligned redirect traps into ERR
        drive_cycle(0, 1, 32'h102, 1, 1, 32'h14);
        check("misalign_set", misalign, 1);
        check("err_if_valid", if_valid, 0);
        drive_cycle(0, 1, 32'h200, 1, 0, 32'h14);
        drive_cycle(0, 0, 0, 1, 0, 32'h14);
        check("misalign_sticky", misalign, 1);
        check("fetch_cnt_8", fetch_cnt, 8);
        rst_n = 1'b0;
        #1;
        check("rst_clr_misalign", misalign, 0);
        check("rst_clr_pc", pc, 32'h0);
        check("rst_clr_cnt", fetch_cnt, 0);

        // Reset asserted mid-burst
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_cycle(0, 0, 0, 1, 0, 32'h0);
        drive_cycle(0, 0, 0, 1, 1, 32'h0);
        drive_cycle(0, 0, 0, 1, 1, 32'h4);
        check("burst_if_valid", if_valid, 1);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("mid_rst_if_valid", if_valid, 0);
        check("mid_rst_if_pc", if_pc, 32'h0);
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_im_req", im_req, 0);
        check("mid_rst_cnt", fetch_cnt, 0);
        im_gnt = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_hold_if_valid", if_valid, 0);

        // Wrap instance: fetches at F0,F4,F8,FC,0 with a 2-bit counter
        gnt2 = 1'b1;
        rst2_n = 1'b1;
        @(posedge clk); #1;
        check("wrap_first_req", im_req2, 1);
        repeat (4) @(posedge clk);
        #1;
        check("wrap_pc0", pc2, 32'h0);
        check("wrap_im_addr0", im_addr2, 14'h0);
        check("wrap_cnt_sat", fetch_cnt2, 2'd3);
        check("wrap_if_pc_fc", if_pc2, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        check("wrap_pc4", pc2, 32'h4);
        check("wrap_if_pc0", if_pc2, 32'h0);
        check("wrap_cnt_hold", fetch_cnt2, 2'd3);

        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
